// File: rtl/fifo_rd_stream_if.sv
// Handshake bundle between the async FIFO read port, the stream converter and the downstream sink.
// master: the converter (drives read enable and the stream); slave: FIFO + sink side.
interface fifo_rd_stream_if #(
    parameter int DATASIZE = 8
) ();
    logic                fifo_empty;
    logic [DATASIZE-1:0] fifo_rdata;
    logic                fifo_r_en;
    logic                flush;
    logic                valid;
    logic                ready;
    logic [DATASIZE-1:0] data;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  flush,
        input  ready,
        output fifo_r_en,
        output valid,
        output data
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output flush,
        output ready,
        input  fifo_r_en,
        input  valid,
        input  data
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Async-FIFO read port to valid/ready stream: 2-entry queue plus one in-flight read, 1 word/cycle.
// Optional pop counter o_beat_cnt is built when FIFO_RD_STREAM_BEAT_CNT_EN is defined.
module fifo_rd_stream #(
    parameter int DATASIZE = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fifo_rd_stream_if.master      bus
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    ,
    output logic [15:0]           o_beat_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DATASIZE-1:0] head_r;
    logic [DATASIZE-1:0] tail_r;
    logic [DATASIZE-1:0] head_nxt_s;
    logic [DATASIZE-1:0] tail_nxt_s;
    logic                inflight_r;
    logic                push_s;
    logic                pop_s;
    logic                valid_s;
    logic                rd_en_s;
    logic [1:0]          occ_s;
    logic [2:0]          demand_s;

    // Handshake terms; a read is issued only if the word it returns will have a free slot.
    always_comb begin
        occ_s    = state_r;
        push_s   = inflight_r;
        valid_s  = !i_rst && (state_r != S_EMPTY);
        pop_s    = valid_s && bus.ready;
        demand_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        if (i_rst || bus.flush || bus.fifo_empty) begin
            rd_en_s = 1'b0;
        end else begin
            rd_en_s = (demand_s < 3'd2);
        end
    end

    assign bus.fifo_r_en = rd_en_s;
    assign bus.valid     = valid_s;
    assign bus.data      = i_rst ? {DATASIZE{1'b0}} : head_r;

    // Next occupancy and queue contents from the push/pop pair.
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        case (state_r)
            S_EMPTY: begin
                if (push_s) begin
                    state_nxt_s = S_ONE;
                    head_nxt_s  = bus.fifo_rdata;
                end else begin
                    state_nxt_s = S_EMPTY;
                end
            end
            S_ONE: begin
                if (push_s && pop_s) begin
                    head_nxt_s = bus.fifo_rdata;
                end else if (push_s) begin
                    state_nxt_s = S_TWO;
                    tail_nxt_s  = bus.fifo_rdata;
                end else if (pop_s) begin
                    state_nxt_s = S_EMPTY;
                end else begin
                    state_nxt_s = S_ONE;
                end
            end
            S_TWO: begin
                // A push without a pop cannot happen here: the read would not have been issued.
                if (push_s && pop_s) begin
                    head_nxt_s = tail_r;
                    tail_nxt_s = bus.fifo_rdata;
                end else if (pop_s) begin
                    state_nxt_s = S_ONE;
                    head_nxt_s  = tail_r;
                end else begin
                    state_nxt_s = S_TWO;
                end
            end
            default: begin
                state_nxt_s = S_EMPTY;
            end
        endcase
    end

    // Queue and in-flight registers; flush behaves like reset for buffered data.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.flush) begin
            state_r    <= S_EMPTY;
            head_r     <= {DATASIZE{1'b0}};
            tail_r     <= {DATASIZE{1'b0}};
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            inflight_r <= rd_en_s;
        end
    end

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    logic [15:0] beat_cnt_r;

    // Counts accepted beats, wrapping naturally at 16 bits.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.flush) begin
            beat_cnt_r <= 16'd0;
        end else if (pop_s) begin
            beat_cnt_r <= beat_cnt_r + 16'd1;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign o_beat_cnt = beat_cnt_r;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO source model, scoreboard of words read and not yet delivered,
// and an independent monitor that checks every accepted beat against the scoreboard.
module tb_fifo_rd_stream;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATASIZE(DW)) bus ();

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    logic [15:0] beat_cnt;
    logic [15:0] beats_model;
`endif

    fifo_rd_stream #(.DATASIZE(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
        ,
        .o_beat_cnt (beat_cnt)
`endif
    );

    int          checks = 0;
    int          passes = 0;
    logic [7:0]  src[$];
    logic [7:0]  sb[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every accepted beat must be the oldest word read and not yet discarded.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_valid", int'(bus.valid), 0);
            check("rst_data", int'(bus.data), 0);
            check("rst_ren", int'(bus.fifo_r_en), 0);
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(bus.valid), 1);
                check("stall_data", int'(bus.data), int'(prev_data));
            end
            if (bus.valid && bus.ready) begin
                if (sb.size() == 0) check("spurious_beat", 1, 0);
                else check("beat_data", int'(bus.data), int'(sb.pop_front()));
            end
        end
        prev_stall = !rst && !bus.flush && bus.valid && !bus.ready;
        prev_data  = bus.data;
    end

    task automatic add_word(input logic [7:0] w);
        src.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock: sample read enable mid-cycle, then play the FIFO's part at the edge.
    task automatic step();
        logic ren;
        logic do_clear;
        @(negedge clk);
        ren      = bus.fifo_r_en;
        do_clear = rst || bus.flush;
        if (bus.fifo_empty || bus.flush || rst) check("ren_blocked", int'(ren), 0);
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
        if (bus.valid && bus.ready) beats_model = beats_model + 16'd1;
`endif
        @(posedge clk);
        #1;
        if (do_clear) begin
            sb.delete();
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
            beats_model = 16'd0;
`endif
        end
        if (ren && src.size() > 0) begin
            bus.fifo_rdata = src.pop_front();
            sb.push_back(bus.fifo_rdata);
        end
        bus.fifo_empty = (src.size() == 0);
        check("outstanding_le_2", int'(sb.size() <= 2), 1);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 8 && !bus.valid; i++) step();
        check(name, int'(bus.valid), 1);
    endtask

    task automatic drain(input string name);
        bus.ready = 1'b1;
        for (int i = 0; i < 40 && (src.size() != 0 || sb.size() != 0 || bus.valid); i++) step();
        check(name, int'(bus.valid), 0);
    endtask

    initial begin
        int n;
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst            = 1'b1;
        bus.flush      = 1'b0;
        bus.ready      = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = 8'h00;
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
        beats_model = 16'd0;
`endif
        repeat (3) step();
        rst = 1'b0;

        // Idle with an empty FIFO.
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_ren", int'(bus.fifo_r_en), 0);
            check("idle_valid", int'(bus.valid), 0);
        end

        // Three words streamed with ready high: first beat two edges after empty drops.
        bus.ready = 1'b1;
        add_word(8'h11); add_word(8'h22); add_word(8'h33);
        n = 0;
        for (int i = 0; i < 10 && !bus.valid; i++) begin
            step();
            n++;
        end
        check("first_latency", n, 2);
        check("stream0", int'(bus.data), 8'h11);
        step();
        check("stream1_valid", int'(bus.valid), 1);
        check("stream1", int'(bus.data), 8'h22);
        step();
        check("stream2_valid", int'(bus.valid), 1);
        check("stream2", int'(bus.data), 8'h33);
        drain("drain_a");

        // Five words with a stalled sink: only two reads, then back-to-back delivery.
        bus.ready = 1'b0;
        for (int i = 0; i < 5; i++) add_word(8'h40 + 8'(i));
        repeat (6) step();
        check("stall_reads", 5 - src.size(), 2);
        check("stall_head_valid", int'(bus.valid), 1);
        check("stall_head", int'(bus.data), 8'h40);
        bus.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("b2b_valid", int'(bus.valid), 1);
            check("b2b_data", int'(bus.data), 8'h40 + i);
            step();
        end
        drain("drain_b");

        // Flush with one word buffered and one in flight.
        bus.ready = 1'b0;
        add_word(8'h61);
        wait_valid("flush_setup_valid");
        add_word(8'h62);
        step();
        check("flush_read_issued", src.size(), 0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_valid", int'(bus.valid), 0);
        bus.ready = 1'b1;
        add_word(8'h63);
        wait_valid("post_flush_valid");
        check("post_flush_data", int'(bus.data), 8'h63);
        drain("drain_c");

        // Reset with the queue full; streaming resumes from the next FIFO word.
        bus.ready = 1'b0;
        add_word(8'h71); add_word(8'h72); add_word(8'h73);
        repeat (5) step();
        check("rst_setup_occ", sb.size(), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("post_rst_valid", int'(bus.valid), 0);
        check("post_rst_data", int'(bus.data), 0);
        bus.ready = 1'b1;
        wait_valid("resume_valid");
        check("resume_data", int'(bus.data), 8'h73);
        drain("drain_d");

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0 && src.size() < 8) add_word(8'($urandom));
            bus.ready = ($urandom_range(0, 2) != 0);
            bus.flush = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        bus.flush = 1'b0;
        rst       = 1'b0;
        drain("drain_rand");
        check("sb_empty_end", sb.size(), 0);

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
        check("beat_cnt_model", int'(beat_cnt), int'(beats_model));
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            add_word(8'($urandom));
            step();
        end
        drain("drain_beats");
        check("beat_cnt_wrap", int'(beat_cnt), 1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter: DATASIZE, default 8, data word width in bits.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  synchronous active-high reset.
REQ-005 i_fifo_empty  input  1  read-side empty flag from the async FIFO.
REQ-006 i_fifo_rdata  input  DATASIZE  FIFO read data; valid on the cycle after o_fifo_r_en was high.
REQ-007 o_fifo_r_en  output  1  FIFO read request, combinational from registered state and i_fifo_empty.
REQ-008 i_flush  input  1  discard all buffered and in-flight words.
REQ-009 o_valid  output  1  downstream stream valid.
REQ-010 i_ready  input  1  downstream stream ready.
REQ-011 o_data  output  DATASIZE  downstream stream data.

Function
REQ-012 The block SHALL convert the FIFO read port into a valid/ready stream with 1 word/cycle sustained throughput.
REQ-013 Buffering SHALL be a 2-entry output queue (head, tail) plus a 1-bit in-flight flag tracking a read issued in the previous cycle.
REQ-014 States SHALL be encoded by occupancy: S_EMPTY (0), S_ONE (1), S_TWO (2).
REQ-015 o_fifo_r_en SHALL be 1 iff !i_rst && !i_flush && !i_fifo_empty && (occupancy + inflight - pop) < 2, where pop = o_valid && i_ready.
REQ-016 inflight SHALL register o_fifo_r_en each cycle; when inflight is 1, i_fifo_rdata SHALL be written into the queue that cycle (push).
REQ-017 o_valid SHALL equal (occupancy != 0); o_data SHALL equal the head entry.
REQ-018 A transfer (pop) SHALL occur when o_valid && i_ready; the tail SHALL move to the head in the same edge.
REQ-019 Transitions: EMPTY->ONE on push; ONE->TWO on push without pop; TWO->ONE on pop without push; ONE->EMPTY on pop without push; simultaneous push and pop SHALL hold the state.
REQ-020 Push with pop in S_EMPTY is impossible (o_valid=0); push in S_TWO without pop SHALL never occur (guaranteed by REQ-015).
REQ-021 o_data and o_valid SHALL remain stable while o_valid && !i_ready.
REQ-022 Latency: first word SHALL appear on o_valid 2 cycles after i_fifo_empty deasserts with the queue empty.
REQ-023 i_flush SHALL, at the next edge, set occupancy to 0, clear inflight, and drop the in-flight word; o_fifo_r_en SHALL be 0 during the flush cycle.
REQ-024 i_fifo_empty rising while inflight is 1 SHALL not cancel the pending push.

Reset
REQ-025 On i_rst high at a clock edge: occupancy 0, inflight 0, head/tail 0, beat counter 0.
REQ-026 While i_rst is high: o_valid=0, o_data=0, o_fifo_r_en=0; reset mid-transfer SHALL discard the in-flight word.

Configuration
REQ-027 Macro FIFO_RD_STREAM_BEAT_CNT_EN: when defined, add output o_beat_cnt (16 bits) counting pops, wrapping 16'hFFFF->0, cleared by i_rst and i_flush.
REQ-028 Without FIFO_RD_STREAM_BEAT_CNT_EN, the o_beat_cnt port and its counter SHALL not exist; all other behaviour is identical.

Verification
REQ-029 Reset then i_fifo_empty=1 for 10 cycles -> o_fifo_r_en=0, o_valid=0 throughout.
REQ-030 FIFO holds 0x11,0x22,0x33, i_ready=1 -> o_data 0x11,0x22,0x33 on consecutive cycles, first 2 cycles after empty deasserts.
REQ-031 FIFO holds 5 words, i_ready=0 -> exactly 2 reads issued, occupancy 2, o_data=first word stable; i_ready=1 -> remaining words follow back-to-back.
REQ-032 i_flush in the cycle after a read is issued with occupancy 1 -> next cycle o_valid=0, dropped word never appears, no read issued during flush.
REQ-033 i_rst asserted mid-stream with occupancy 2 -> next cycle o_valid=0, o_data=0; after release, streaming resumes from the next FIFO word.
REQ-034 With FIFO_RD_STREAM_BEAT_CNT_EN, 65537 pops -> o_beat_cnt=1.
